// File: rtl/arm_pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// parameter defaults, the control-output bundle and the fixed control
// patterns that the controller selects between.
package arm_pipe_pkg;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_MEMWAIT = 2'd2
  } state_t;

  localparam int INIT_CYCLES_DEF  = 2;
  localparam int BUSY_TIMEOUT_DEF = 255;

  // Pipeline control bundle driven by the controller every cycle.
  typedef struct packed {
    logic pc_enable;
    logic if_id_enable;
    logic if_id_flush;
    logic id_ex_nop;
    logic pipe_freeze;
  } ctrl_t;

  // Idle/NOP pattern: front end held, IF/ID and ID/EX fed bubbles.
  localparam ctrl_t CTRL_INIT     = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  // Memory stall: everything holds, nothing is squashed.
  localparam ctrl_t CTRL_BUSY     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  // Taken branch: fetch the target, squash IF/ID and ID/EX.
  localparam ctrl_t CTRL_BRANCH   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  // Load-use: hold PC and IF/ID, insert one bubble into ID/EX.
  localparam ctrl_t CTRL_LOADUSE  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  // Normal flow.
  localparam ctrl_t CTRL_NORMAL   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  // Load in EX writes a register that the ID instruction reads.
  function automatic logic load_use_hit(
    input logic       mem_read,
    input logic [3:0] wa,
    input logic [3:0] rn,
    input logic       uses_rn,
    input logic [3:0] rm,
    input logic       uses_rm
  );
    return mem_read & ((uses_rn & (wa == rn)) | (uses_rm & (wa == rm)));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// 16-bit saturating event counter with synchronous clear.
module sat_counter (
  input  logic        i_clk,
  input  logic        i_clear,
  input  logic        i_inc,
  output logic [15:0] o_count
);

  logic [15:0] r_count;

  // Count enabled events, stick at all-ones, clear wins over increment.
  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != 16'hFFFF)) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: holds the pipeline idle after reset, then
// resolves memory stalls, taken-branch squashes and load-use bubbles with
// fixed priority. All control outputs are combinational from the current
// state and inputs. dbg_state exposes the FSM state for observation.
module hazard_controller
  import arm_pipe_pkg::*;
#(
  parameter int INIT_CYCLES  = INIT_CYCLES_DEF,
  parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  id_rn,
  input  logic [3:0]  id_rm,
  input  logic        id_uses_rn,
  input  logic        id_uses_rm,
  input  logic [3:0]  ex_wa,
  input  logic        ex_mem_read,
  input  logic        ex_branch_taken,
  input  logic        mem_busy,
  output logic        pc_enable,
  output logic        if_id_enable,
  output logic        if_id_flush,
  output logic        id_ex_nop,
  output logic        pipe_freeze,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count,
  output logic        mem_timeout,
  output state_t      dbg_state
);

  // Last INIT cycle index and the busy count at which the timeout arms.
  localparam logic [15:0] INIT_LAST = 16'(INIT_CYCLES - 1);
  localparam logic [15:0] BUSY_LAST = 16'(BUSY_TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_init_cnt;
  logic [15:0] r_busy_cnt;
  logic        r_mem_timeout;
  ctrl_t       w_ctrl;
  logic        w_load_use;
  logic        w_active;
  logic        w_stall_inc;
  logic        w_flush_inc;

  assign w_load_use = load_use_hit(ex_mem_read, ex_wa, id_rn, id_uses_rn,
                                   id_rm, id_uses_rm);
  assign w_active   = (r_state != ST_INIT);

  // Next-state and control-output decode; reset overrides with INIT values.
  always_comb begin
    w_state_nxt = r_state;
    w_ctrl      = CTRL_NORMAL;
    w_stall_inc = 1'b0;
    w_flush_inc = 1'b0;
    if (reset) begin
      w_ctrl      = CTRL_INIT;
      w_state_nxt = ST_INIT;
    end else begin
      case (r_state)
        ST_INIT: begin
          w_ctrl = CTRL_INIT;
          if (r_init_cnt >= INIT_LAST) begin
            w_state_nxt = ST_RUN;
          end
        end
        default: begin
          // RUN and MEMWAIT share the same priority decode.
          if (mem_busy) begin
            w_ctrl      = CTRL_BUSY;
            w_state_nxt = ST_MEMWAIT;
          end else if (ex_branch_taken) begin
            // A coincident load-use is moot: the dependent op is squashed.
            w_ctrl      = CTRL_BRANCH;
            w_flush_inc = 1'b1;
            w_state_nxt = ST_RUN;
          end else if (w_load_use) begin
            w_ctrl      = CTRL_LOADUSE;
            w_state_nxt = ST_RUN;
          end else begin
            w_ctrl      = CTRL_NORMAL;
            w_state_nxt = ST_RUN;
          end
          w_stall_inc = ~w_ctrl.pc_enable;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Counts cycles spent in INIT since reset released.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_init_cnt <= '0;
    end else if (r_state == ST_INIT) begin
      r_init_cnt <= r_init_cnt + 16'd1;
    end
  end

  // Consecutive mem_busy cycle counter, saturating, cleared when not busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy_cnt <= '0;
    end else if (w_active && mem_busy) begin
      if (r_busy_cnt != 16'hFFFF) begin
        r_busy_cnt <= r_busy_cnt + 16'd1;
      end
    end else begin
      r_busy_cnt <= '0;
    end
  end

  // Sticky timeout: arms on the busy cycle that brings the count to the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_timeout <= 1'b0;
    end else if (w_active && mem_busy && (r_busy_cnt >= BUSY_LAST)) begin
      r_mem_timeout <= 1'b1;
    end
  end

  sat_counter u_stall_cnt (
    .i_clk   (clk),
    .i_clear (reset),
    .i_inc   (w_stall_inc),
    .o_count (stall_cycles)
  );

  sat_counter u_flush_cnt (
    .i_clk   (clk),
    .i_clear (reset),
    .i_inc   (w_flush_inc),
    .o_count (flush_count)
  );

  assign pc_enable    = w_ctrl.pc_enable;
  assign if_id_enable = w_ctrl.if_id_enable;
  assign if_id_flush  = w_ctrl.if_id_flush;
  assign id_ex_nop    = w_ctrl.id_ex_nop;
  assign pipe_freeze  = w_ctrl.pipe_freeze;
  assign mem_timeout  = r_mem_timeout;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_hazard_controller.sv
// Testbench for hazard_controller: directed scenarios followed by random
// traffic, each cycle's expected outputs pushed to a queue by the driver and
// popped/compared by an independent monitor on the falling edge.
module tb_hazard_controller;
  import arm_pipe_pkg::*;

  localparam int INIT_N = 2;
  localparam int TMO    = 255;
  localparam int W      = 40;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  id_rn, id_rm, ex_wa;
  logic        id_uses_rn, id_uses_rm, ex_mem_read, ex_branch_taken, mem_busy;
  logic        pc_enable, if_id_enable, if_id_flush, id_ex_nop, pipe_freeze;
  logic [15:0] stall_cycles, flush_count;
  logic        mem_timeout;
  state_t      dbg_state;

  always #5 clk = ~clk;

  hazard_controller #(.INIT_CYCLES(INIT_N), .BUSY_TIMEOUT(TMO)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rn           (id_rn),
    .id_rm           (id_rm),
    .id_uses_rn      (id_uses_rn),
    .id_uses_rm      (id_uses_rm),
    .ex_wa           (ex_wa),
    .ex_mem_read     (ex_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .mem_busy        (mem_busy),
    .pc_enable       (pc_enable),
    .if_id_enable    (if_id_enable),
    .if_id_flush     (if_id_flush),
    .id_ex_nop       (id_ex_nop),
    .pipe_freeze     (pipe_freeze),
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count),
    .mem_timeout     (mem_timeout),
    .dbg_state       (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: phase, cycles spent idle, busy run length, counters.
  state_t m_state;
  int     m_init_seen;
  int     m_busy_run;
  int     m_stall;
  int     m_flush;
  bit     m_tmo;

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic model_step(input bit rst, input logic [3:0] rn, input logic [3:0] rm,
                            input bit urn, input bit urm, input logic [3:0] wa,
                            input bit mr, input bit br, input bit busy);
    logic [4:0] c;   // {pc_enable, if_id_enable, if_id_flush, id_ex_nop, pipe_freeze}
    bit lu;
    lu = mr && ((urn && (wa == rn)) || (urm && (wa == rm)));
    if (rst || (m_state == ST_INIT)) c = 5'b00110;
    else if (busy)                   c = 5'b00001;
    else if (br)                     c = 5'b11110;
    else if (lu)                     c = 5'b00010;
    else                             c = 5'b11000;
    exp_q.push_back({c, m_tmo, 16'(m_stall), 16'(m_flush), m_state});
    if (rst) begin
      m_state = ST_INIT; m_init_seen = 0; m_busy_run = 0;
      m_stall = 0; m_flush = 0; m_tmo = 1'b0;
    end else if (m_state == ST_INIT) begin
      m_init_seen++;
      if (m_init_seen >= INIT_N) m_state = ST_RUN;
    end else begin
      if (!c[4]) m_stall = sat16(m_stall + 1);
      if (!busy && br) m_flush = sat16(m_flush + 1);
      if (busy) begin
        m_busy_run++;
        if (m_busy_run >= TMO) m_tmo = 1'b1;
        m_state = ST_MEMWAIT;
      end else begin
        m_busy_run = 0;
        m_state = ST_RUN;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit rst, input logic [3:0] rn, input logic [3:0] rm,
                       input bit urn, input bit urm, input logic [3:0] wa,
                       input bit mr, input bit br, input bit busy);
    @(posedge clk);
    #1;
    reset = rst; id_rn = rn; id_rm = rm; id_uses_rn = urn; id_uses_rm = urm;
    ex_wa = wa; ex_mem_read = mr; ex_branch_taken = br; mem_busy = busy;
    model_step(rst, rn, rm, urn, urm, wa, mr, br, busy);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'd1, 4'd2, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic busy_cycles(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'd1, 4'd2, 1'b1, 1'b1, 4'd1, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic reset_cycles(input int n, input bit busy);
    for (int i = 0; i < n; i++) drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, busy);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] exp_v;
    logic [W-1:0] got_v;
    cyc++;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      got_v = {pc_enable, if_id_enable, if_id_flush, id_ex_nop, pipe_freeze,
               mem_timeout, stall_cycles, flush_count, dbg_state};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL outputs cyc=%0d got ctl=%b tmo=%b stall=%0d flush=%0d st=%0d  exp ctl=%b tmo=%b stall=%0d flush=%0d st=%0d",
                 cyc, got_v[39:35], got_v[34], got_v[33:18], got_v[17:2], got_v[1:0],
                 exp_v[39:35], exp_v[34], exp_v[33:18], exp_v[17:2], exp_v[1:0]);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int busy_left;
    reset = 1'b1; id_rn = '0; id_rm = '0; id_uses_rn = 1'b0; id_uses_rm = 1'b0;
    ex_wa = '0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0; mem_busy = 1'b0;
    // One reset edge establishes known register state before checking starts.
    @(posedge clk);
    m_state = ST_INIT; m_init_seen = 0; m_busy_run = 0;
    m_stall = 0; m_flush = 0; m_tmo = 1'b0;

    // Reset held, then released: two idle cycles, then running.
    reset_cycles(2, 1'b0);
    idle(4);
    // Single load-use on rn.
    drive(1'b0, 4'd5, 4'd0, 1'b1, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0);
    idle(2);
    // Load-use on rm only; rn unused so its match must not matter.
    drive(1'b0, 4'd7, 4'd9, 1'b0, 1'b1, 4'd9, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 4'd7, 4'd9, 1'b0, 1'b0, 4'd7, 1'b1, 1'b0, 1'b0);
    // Branch coincident with load-use: branch wins.
    drive(1'b0, 4'd5, 4'd0, 1'b1, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0);
    idle(2);
    // Three busy cycles with branch and load-use also asserted.
    busy_cycles(3);
    idle(2);
    // Reset during MEMWAIT.
    busy_cycles(2);
    reset_cycles(1, 1'b1);
    idle(4);
    // Long busy through the timeout, then reset mid-freeze.
    busy_cycles(260);
    reset_cycles(2, 1'b1);
    idle(4);

    // Random traffic with short busy bursts and occasional resets.
    busy_left = 0;
    for (int i = 0; i < 3000; i++) begin
      bit b;
      if (busy_left > 0) begin
        b = 1'b1; busy_left--;
      end else if ($urandom_range(0, 11) == 0) begin
        b = 1'b1; busy_left = $urandom_range(0, 5);
      end else begin
        b = 1'b0;
      end
      drive(($urandom_range(0, 199) == 0),
            4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 3)),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0), b);
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
